// File: rtl/uart_rx_cfg.sv
// UART receiver with run-time word length, parity and stop-bit selection,
// OS-times oversampling from a programmable baud divisor and a one-word output buffer.
module uart_rx_cfg #(
  parameter int DVSR_W = 32,
  parameter int OS     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        data_bits,
  input  logic [1:0]        parity_mode,
  input  logic              stop_bits,
  output logic [7:0]        r_data,
  output logic              r_valid,
  input  logic              r_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              brk,
  output logic              overrun,
  input  logic              err_clr
);

  localparam int            SW    = $clog2(OS);
  localparam logic [SW-1:0] S_MID = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DVSR_W-1:0] cnt_q, cnt_d;
  logic              tick;
  logic [1:0]        sync_q, sync_d;
  logic              rx_s;

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [2:0]        n_q, n_d;
  logic              stop_q, stop_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [2:0]        last_q, last_d;
  logic [1:0]        pmode_q, pmode_d;
  logic              two_q, two_d;
  logic              pbit_q, pbit_d;
  logic              ferr_q, ferr_d;

  logic [7:0]        r_data_q, r_data_d;
  logic              r_valid_q, r_valid_d;
  logic              perr_q, perr_d;
  logic              fout_q, fout_d;
  logic              brk_q, brk_d;
  logic              ovr_q, ovr_d;

  logic              done, ferr_now, par_en, par_x, perr_new, brk_new;

  // A divisor lowered below the running count forces an immediate wrap.
  always_comb begin
    tick  = (cnt_q == dvsr);
    cnt_d = (cnt_q >= dvsr) ? '0 : cnt_q + DVSR_W'(1);
  end

  always_comb begin
    sync_d = {sync_q[0], rx};
    rx_s   = sync_q[1];
  end

  always_comb begin
    par_en   = (pmode_q == 2'b01) || (pmode_q == 2'b10);
    par_x    = (^shreg_q) ^ pbit_q;
    ferr_now = ferr_q | ~rx_s;
    case (pmode_q)
      2'b01:   perr_new = par_x;
      2'b10:   perr_new = ~par_x;
      default: perr_new = 1'b0;
    endcase
    brk_new = ferr_now & (shreg_q == 8'h00) & ~(par_en & pbit_q);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    pmode_d = pmode_q;
    two_d   = two_q;
    pbit_d  = pbit_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        // Frame format is frozen here so mid-frame config writes are harmless.
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
          last_d  = {1'b1, data_bits};
          pmode_d = parity_mode;
          two_d   = stop_bits;
          shreg_d = 8'h00;
          pbit_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            s_d     = '0;
            n_d     = 3'd0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_END) begin
            s_d          = '0;
            shreg_d[n_q] = rx_s;
            n_d          = n_q + 3'd1;
            if (n_q == last_q) begin
              stop_d  = 1'b0;
              state_d = par_en ? PARITY : STOP;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (s_q == S_END) begin
            s_d     = '0;
            pbit_d  = rx_s;
            stop_d  = 1'b0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_END) begin
            s_d    = '0;
            ferr_d = ferr_now;
            if (stop_q == two_q) begin
              done    = 1'b1;
              state_d = IDLE;
            end else begin
              stop_d = 1'b1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A finished frame only lands if the buffer is empty or being drained this cycle.
  always_comb begin
    r_data_d  = r_data_q;
    r_valid_d = r_valid_q & ~r_ready;
    perr_d    = perr_q;
    fout_d    = fout_q;
    brk_d     = brk_q;
    ovr_d     = ovr_q & ~err_clr;
    if (done) begin
      if (!r_valid_q || r_ready) begin
        r_data_d  = shreg_q;
        r_valid_d = 1'b1;
        perr_d    = perr_new;
        fout_d    = ferr_now;
        brk_d     = brk_new;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= 3'd0;
      stop_q    <= 1'b0;
      shreg_q   <= 8'h00;
      last_q    <= 3'd0;
      pmode_q   <= 2'b00;
      two_q     <= 1'b0;
      pbit_q    <= 1'b0;
      ferr_q    <= 1'b0;
      r_data_q  <= 8'h00;
      r_valid_q <= 1'b0;
      perr_q    <= 1'b0;
      fout_q    <= 1'b0;
      brk_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sync_q    <= sync_d;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      stop_q    <= stop_d;
      shreg_q   <= shreg_d;
      last_q    <= last_d;
      pmode_q   <= pmode_d;
      two_q     <= two_d;
      pbit_q    <= pbit_d;
      ferr_q    <= ferr_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      perr_q    <= perr_d;
      fout_q    <= fout_d;
      brk_q     <= brk_d;
      ovr_q     <= ovr_d;
    end
  end

  assign r_data     = r_data_q;
  assign r_valid    = r_valid_q;
  assign parity_err = perr_q;
  assign frame_err  = fout_q;
  assign brk        = brk_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: frames are built from data/format choices and the expected
// word and flags are derived arithmetically, then matched against every held output.
module tb_uart_rx_cfg;

  localparam int OS     = 16;
  localparam int DVSR_W = 32;

  logic              clk;
  logic              reset;
  logic              rx;
  logic [DVSR_W-1:0] dvsr;
  logic [1:0]        data_bits;
  logic [1:0]        parity_mode;
  logic              stop_bits;
  logic [7:0]        r_data;
  logic              r_valid;
  logic              r_ready;
  logic              parity_err;
  logic              frame_err;
  logic              brk;
  logic              overrun;
  logic              err_clr;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } word_t;

  word_t exp_q[$];
  int    n_tests    = 0;
  int    n_fail     = 0;
  bit    chk_ovr_en = 1'b0;
  bit    rand_phase = 1'b0;

  uart_rx_cfg #(.DVSR_W(DVSR_W), .OS(OS)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .dvsr       (dvsr),
    .data_bits  (data_bits),
    .parity_mode(parity_mode),
    .stop_bits  (stop_bits),
    .r_data     (r_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .brk        (brk),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Whenever a word is held it must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (r_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_word: got r_data=0x%0h, required no word", r_data);
        end else begin
          check_output("word_data", {24'h0, r_data}, {24'h0, exp_q[0].d});
          check_output("word_parity_err", {31'h0, parity_err}, {31'h0, exp_q[0].pe});
          check_output("word_frame_err", {31'h0, frame_err}, {31'h0, exp_q[0].fe});
          check_output("word_brk", {31'h0, brk}, {31'h0, exp_q[0].bk});
          if (r_ready === 1'b1) exp_q.delete(0);
        end
      end
      if (chk_ovr_en) check_output("overrun_quiet", {31'h0, overrun}, 32'h0);
    end
  end

  function automatic int bit_cycles();
    return OS * (int'(dvsr) + 1);
  endfunction

  task automatic drive_bit(input logic v, input int bt);
    rx = v;
    repeat (bt) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input int nb, input logic [1:0] pm,
                                input bit pflip, input bit two, input logic [1:0] stop_vals,
                                input bit deliver, input bit scramble);
    logic [7:0] dm;
    logic       pbit, x, par_en;
    word_t      w;
    int         bt;
    dm     = d & 8'((1 << nb) - 1);
    par_en = (pm == 2'b01) || (pm == 2'b10);
    pbit   = ((pm == 2'b10) ? ~(^dm) : (^dm)) ^ pflip;
    x      = (^dm) ^ pbit;
    w.d    = dm;
    w.pe   = (pm == 2'b01) ? x : ((pm == 2'b10) ? ~x : 1'b0);
    w.fe   = ~stop_vals[0] | (two & ~stop_vals[1]);
    w.bk   = w.fe && (dm == 8'h00) && (!par_en || !pbit);
    data_bits   = 2'(nb - 5);
    parity_mode = pm;
    stop_bits   = two;
    if (deliver) exp_q.push_back(w);
    bt = bit_cycles();
    drive_bit(1'b0, bt);
    if (scramble) begin
      data_bits   = 2'($urandom);
      parity_mode = 2'($urandom);
      stop_bits   = 1'($urandom);
    end
    for (int i = 0; i < nb; i++) drive_bit(dm[i], bt);
    if (par_en) drive_bit(pbit, bt);
    drive_bit(stop_vals[0], bt);
    if (two) drive_bit(stop_vals[1], bt);
    rx = 1'b1;
  endtask

  task automatic check_held(input string tag, input logic [7:0] d, input logic pe,
                            input logic fe, input logic bk);
    check_output({tag, "_valid"}, {31'h0, r_valid}, 32'h1);
    check_output({tag, "_data"}, {24'h0, r_data}, {24'h0, d});
    check_output({tag, "_parity_err"}, {31'h0, parity_err}, {31'h0, pe});
    check_output({tag, "_frame_err"}, {31'h0, frame_err}, {31'h0, fe});
    check_output({tag, "_brk"}, {31'h0, brk}, {31'h0, bk});
  endtask

  task automatic accept_word();
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    r_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx    = 1'b1;
    exp_q.delete();
    #1;
    check_output("reset_valid", {31'h0, r_valid}, 32'h0);
    check_output("reset_data", {24'h0, r_data}, 32'h0);
    check_output("reset_flags", {29'h0, parity_err, frame_err, brk}, 32'h0);
    check_output("reset_overrun", {31'h0, overrun}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bt;
    reset       = 1'b1;
    rx          = 1'b1;
    r_ready     = 1'b0;
    err_clr     = 1'b0;
    dvsr        = '0;
    data_bits   = 2'b11;
    parity_mode = 2'b00;
    stop_bits   = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // 8N1 at one tick per clock, buffer held then drained.
    dvsr = 0;
    apply_stimulus(8'hA5, 8, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    check_held("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    accept_word();
    check_output("a5_drained", {31'h0, r_valid}, 32'h0);

    // 7E1 with wrong then right parity bit.
    dvsr = 3;
    apply_stimulus(8'h35, 7, 2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    check_held("p35_bad", 8'h35, 1'b1, 1'b0, 1'b0);
    accept_word();
    apply_stimulus(8'h35, 7, 2'b01, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    check_held("p35_good", 8'h35, 1'b0, 1'b0, 1'b0);
    accept_word();

    // 5O1, right-justified short word.
    dvsr = 1;
    apply_stimulus(8'h1F, 5, 2'b10, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    check_held("o1f_good", 8'h1F, 1'b0, 1'b0, 1'b0);
    accept_word();
    apply_stimulus(8'h1F, 5, 2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    check_held("o1f_bad", 8'h1F, 1'b1, 1'b0, 1'b0);
    accept_word();

    // 8N2 with a low second stop bit, then a 12-bit-time break.
    dvsr = 0;
    bt   = bit_cycles();
    apply_stimulus(8'h3C, 8, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
    check_held("stop2_low", 8'h3C, 1'b0, 1'b1, 1'b0);
    accept_word();
    repeat (2 * bt) @(posedge clk);
    #1;
    do_reset();
    apply_stimulus(8'h00, 8, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    drive_bit(1'b0, bt);
    rx = 1'b1;
    check_held("break", 8'h00, 1'b0, 1'b1, 1'b1);
    accept_word();
    repeat (bt) @(posedge clk);
    #1;
    do_reset();

    // Overrun: second frame dropped while the first is still held.
    apply_stimulus(8'h11, 8, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    apply_stimulus(8'h22, 8, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    check_held("ovr_hold", 8'h11, 1'b0, 1'b0, 1'b0);
    check_output("ovr_set", {31'h0, overrun}, 32'h1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check_output("ovr_cleared", {31'h0, overrun}, 32'h0);
    accept_word();
    apply_stimulus(8'h11, 8, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    fork
      apply_stimulus(8'h22, 8, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
      begin
        repeat (5 * bt) @(posedge clk);
        #1;
        r_ready = 1'b1;
      end
    join
    check_output("ready_second_data", {24'h0, r_data}, 32'h22);
    check_output("ready_second_ovr", {31'h0, overrun}, 32'h0);
    r_ready = 1'b0;

    // Glitch shorter than half a bit, then a frame cut by reset.
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * bt) @(posedge clk);
    #1;
    check_output("glitch_no_word", {31'h0, r_valid}, 32'h0);
    data_bits   = 2'b11;
    parity_mode = 2'b00;
    stop_bits   = 1'b0;
    drive_bit(1'b0, bt);
    drive_bit(1'b0, bt);
    drive_bit(1'b1, bt);
    drive_bit(1'b0, bt);
    rx = 1'b1;
    repeat (bt / 2) @(posedge clk);
    #1;
    do_reset();
    repeat (bt) @(posedge clk);
    #1;
    apply_stimulus(8'h5A, 8, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
    check_held("after_reset", 8'h5A, 1'b0, 1'b0, 1'b0);
    accept_word();

    // Random formats, divisors and consumer back-pressure.
    rand_phase = 1'b1;
    chk_ovr_en = 1'b1;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          int gap;
          dvsr = DVSR_W'($urandom_range(0, 3));
          apply_stimulus(8'($urandom), int'($urandom_range(5, 8)), 2'($urandom),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b11, 1'b1, 1'b1);
          gap = int'($urandom_range(0, 20));
          repeat (gap + 1) @(posedge clk);
          #1;
        end
        rand_phase = 1'b0;
      end
      begin
        while (rand_phase) begin
          @(posedge clk);
          #1;
          r_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    r_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_ovr_en = 1'b0;
    check_output("queue_drained", exp_q.size(), 32'h0);
    check_output("final_overrun", {31'h0, overrun}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DVSR_W, default 32, width of the baud divisor input.
REQ-002 SHALL have parameter OS, default 16, oversampling ticks per bit; power of two, at least 8.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx, input, 1 bit: serial line; idle high; asynchronous to clk.
REQ-006 SHALL have port dvsr, input, DVSR_W bits: tick period is dvsr+1 clk cycles.
REQ-007 SHALL have port data_bits, input, 2 bits: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-008 SHALL have port parity_mode, input, 2 bits: 00=none, 01=even, 10=odd, 11=none.
REQ-009 SHALL have port stop_bits, input, 1 bit: 0=one stop bit, 1=two stop bits.
REQ-010 SHALL have port r_data, output, 8 bits: received word, right-justified, unused MSBs zero.
REQ-011 SHALL have port r_valid, output, 1 bit: r_data and the error flags are valid.
REQ-012 SHALL have port r_ready, input, 1 bit: consumer accepts the word when r_valid&&r_ready.
REQ-013 SHALL have ports parity_err, frame_err and brk, outputs, 1 bit each: per-word flags, qualified by r_valid.
REQ-014 SHALL have port overrun, output, 1 bit: sticky, set when a completed frame is lost.
REQ-015 SHALL have port err_clr, input, 1 bit: single-cycle pulse that clears overrun.

Function
REQ-016 Baud tick: a counter SHALL count 0..dvsr and assert a one-cycle tick when count==dvsr, then wrap to 0; dvsr=0 gives a tick every cycle.
REQ-017 rx SHALL pass through a 2-flop synchroniser (reset value 1); all sampling SHALL use the synchronised value.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with tick counter s (log2 OS bits), bit counter n (3 bits) and stop counter.
REQ-019 IDLE: when synchronised rx==0, SHALL go to START with s=0, and SHALL latch data_bits, parity_mode and stop_bits for the whole frame.
REQ-020 START: on the tick where s==OS/2-1, SHALL go to DATA with s=0, n=0 if rx==0; otherwise a false start SHALL return to IDLE with no output.
REQ-021 DATA: on the tick where s==OS-1, SHALL sample rx LSB-first, reset s, and increment n; after bit nbits-1 SHALL go to PARITY if parity is enabled, else STOP.
REQ-022 PARITY: SHALL sample at s==OS-1; the error is set when the XOR of data and parity bit is 1 (even) or 0 (odd).
REQ-023 STOP: SHALL sample each stop bit at s==OS-1; frame_err SHALL be set if any sampled stop bit is 0.
REQ-024 After the last stop sample, SHALL return to IDLE the next cycle; with two stop bits, IDLE SHALL be entered only after the second.
REQ-025 brk SHALL be set when frame_err=1 and every data bit and the parity bit (if enabled) are 0.
REQ-026 Frame completion: if r_valid==0, or r_ready==1 in the same cycle, SHALL load r_data and the flags and set r_valid the next cycle.
REQ-027 Frame completion while r_valid==1 and r_ready==0: SHALL keep the held word and flags unchanged, discard the new frame, and set overrun.
REQ-028 r_valid SHALL clear the cycle after r_valid&&r_ready unless a new word loads in that same cycle.
REQ-029 overrun SHALL clear on err_clr; if err_clr and a new overrun occur in the same cycle, overrun SHALL stay 1.
REQ-030 Config input changes mid-frame SHALL NOT affect the current frame.
REQ-031 A change of dvsr SHALL take effect from the next counter wrap; if count>dvsr, the counter SHALL wrap to 0 at once.

Reset
REQ-032 Asserting reset SHALL immediately set: FSM to IDLE; s, n and the baud counter to 0; synchroniser flops to 1; r_data to 0x00; r_valid, parity_err, frame_err, brk and overrun to 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; after release, the first output SHALL come only from a fresh start bit.

Verification
REQ-034 dvsr=0, 8N1, send 0xA5 with 16 clk per bit, hold r_ready=0 -> r_valid=1, r_data=0xA5, all flags 0; r_ready=1 for one cycle -> r_valid=0.
REQ-035 dvsr=3, 7 bits, even parity, send 0x35 with parity bit 1 -> r_data=0x35, parity_err=1; resend with parity bit 0 -> parity_err=0.
REQ-036 8N2, send 0x3C with second stop bit 0 -> frame_err=1, brk=0; hold rx low for 12 bit times -> r_data=0x00, frame_err=1, brk=1.
REQ-037 r_ready=0, send 0x11 then 0x22 -> r_data stays 0x11, overrun=1; pulse err_clr -> overrun=0; same frames with r_ready=1 at second completion -> r_data=0x22, overrun=0.
REQ-038 rx low pulse shorter than OS/2 ticks -> no r_valid; reset asserted during bit 3 then a clean 0x5A -> only 0x5A is delivered.
REQ-039 5 bits, odd parity, send 0x1F -> r_data=0x1F, upper 3 bits 0, parity_err per REQ-022.
